fifo_param: RTL

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 95 +++++++++
 1 files changed

// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with occupancy flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.
module fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_enb,
  input  logic                     rd_enb,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra wrap bit, so their difference spans 0..DEPTH.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  always_comb begin
    wr_acc      = wr_enb && !full;
    rd_acc      = rd_enb && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q | (wr_enb & full);
    underflow_d = underflow_q | (rd_enb & empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; reset only empties the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_idx] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem_q[rd_idx];
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc) data_out_d = mem_q[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out_q <= '0;
    else     data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
`endif

endmodule
